// File: rtl/vg_pkg.sv
`default_nettype none
// ============================================================================
// Module   : vg_pkg
// Brief    : Shared types and constants for the vector-generator PC.
// Revision : 1.0
// ============================================================================
package vg_pkg;

    localparam int ADDR_W      = 12;
    localparam int STACK_DEPTH = 4;

    typedef logic [ADDR_W-1:0] vg_addr_t;

    typedef enum logic [2:0] {
        OP_HOLD = 3'd0,
        OP_INC  = 3'd1,
        OP_JUMP = 3'd2,
        OP_PUSH = 3'd3,
        OP_POP  = 3'd4
    } pc_op_t;

    // Strobe priority: load (jump/return) beats push beats fetch increment.
    function automatic pc_op_t decode_op(
        input logic dmaload,
        input logic load_pc,
        input logic dmapush,
        input logic latch0,
        input logic latch2
    );
        if (dmaload)
            return load_pc ? OP_JUMP : OP_POP;
        else if (dmapush)
            return OP_PUSH;
        else if (latch0 || latch2)
            return OP_INC;
        else
            return OP_HOLD;
    endfunction

endpackage
`default_nettype wire

// File: rtl/vg_pc_if.sv
`default_nettype none
// ============================================================================
// Module   : vg_pc_if
// Brief    : Strobe and address bus between the VG decoder and the PC.
// Revision : 1.0
// ============================================================================
interface vg_pc_if;
    import vg_pkg::*;

    vg_addr_t count_in;
    logic     dmaload;
    logic     load_pc;
    logic     dmapush;
    logic     latch0;
    logic     latch2;
    vg_addr_t count_out;

    modport master (
        output count_in, dmaload, load_pc, dmapush, latch0, latch2,
        input  count_out
    );

    modport slave (
        input  count_in, dmaload, load_pc, dmapush, latch0, latch2,
        output count_out
    );
endinterface
`default_nettype wire

// File: rtl/vg_pc_stack.sv
`default_nettype none
// ============================================================================
// Module   : vg_pc_stack
// Brief    : Return-address LIFO with a free-wrapping pointer (no flags).
// Revision : 1.0
// ============================================================================
module vg_pc_stack #(
    parameter int DEPTH = 4,
    parameter int W     = 12
) (
    input  wire logic         clk,
    input  wire logic         rst,
    input  wire logic         i_push,
    input  wire logic         i_pop,
    input  wire logic [W-1:0] i_wdata,
    output logic      [W-1:0] o_top
);
    localparam int SP_W = $clog2(DEPTH);

    logic [SP_W-1:0] r_sp;
    logic [W-1:0]    r_mem [DEPTH];
    logic [SP_W-1:0] w_top_idx;

    // Pointer arithmetic wraps naturally because DEPTH is a power of two.
    assign w_top_idx = r_sp - SP_W'(1);
    assign o_top     = r_mem[w_top_idx];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sp <= '0;
            for (int i = 0; i < DEPTH; i++)
                r_mem[i] <= '0;
        end else if (i_push) begin
            r_mem[r_sp] <= i_wdata;
            r_sp        <= r_sp + SP_W'(1);
        end else if (i_pop) begin
            r_sp <= w_top_idx;
        end
    end

endmodule
`default_nettype wire

// File: rtl/vg_pc.sv
`default_nettype none
// ============================================================================
// Module   : vg_pc
// Brief    : Vector-generator program counter with return-address stack.
// Revision : 1.0
// ============================================================================
module vg_pc
    import vg_pkg::*;
(
    input  wire logic clk,
    input  wire logic reset,
    vg_pc_if.slave    bus
);
    pc_op_t   w_op;
    vg_addr_t r_pc;
    vg_addr_t w_pc_next;
    vg_addr_t w_stack_top;

    assign w_op = decode_op(bus.dmaload, bus.load_pc, bus.dmapush,
                            bus.latch0, bus.latch2);

    vg_pc_stack #(
        .DEPTH (STACK_DEPTH),
        .W     (ADDR_W)
    ) u_stack (
        .clk     (clk),
        .rst     (reset),
        .i_push  (w_op == OP_PUSH),
        .i_pop   (w_op == OP_POP),
        .i_wdata (r_pc),
        .o_top   (w_stack_top)
    );

    always_comb begin
        w_pc_next = r_pc;
        case (w_op)
            OP_JUMP: w_pc_next = bus.count_in;
            OP_POP:  w_pc_next = w_stack_top;
            OP_INC:  w_pc_next = r_pc + ADDR_W'(1);
            default: w_pc_next = r_pc;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset)
            r_pc <= '0;
        else
            r_pc <= w_pc_next;
    end

    assign bus.count_out = r_pc;

endmodule
`default_nettype wire

// File: tb/tb_vg_pc.sv
`default_nettype none
// ============================================================================
// Module   : tb_vg_pc
// Brief    : Directed self-checking bench for vg_pc.
// Revision : 1.0
// ============================================================================
module tb_vg_pc;
    logic clk = 1'b0;
    logic reset;
    int   n_assert = 0;
    int   n_fail   = 0;

    vg_pc_if bus ();

    vg_pc dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // One clock with the given strobes; outputs are sampled 1 ns after the edge.
    task automatic cyc(input logic rst_v, input logic dl, input logic lp,
                       input logic dp, input logic l0, input logic l2,
                       input logic [11:0] cin);
        reset        = rst_v;
        bus.dmaload  = dl;
        bus.load_pc  = lp;
        bus.dmapush  = dp;
        bus.latch0   = l0;
        bus.latch2   = l2;
        bus.count_in = cin;
        @(posedge clk);
        #1;
        reset        = 1'b0;
        bus.dmaload  = 1'b0;
        bus.load_pc  = 1'b0;
        bus.dmapush  = 1'b0;
        bus.latch0   = 1'b0;
        bus.latch2   = 1'b0;
    endtask

    task automatic chk_pc(input string tag, input logic [11:0] exp);
        n_assert++;
        assert (bus.count_out === exp) else begin
            n_fail++;
            $error("FAIL %s: count_out observed %h expected %h", tag, bus.count_out, exp);
        end
    endtask

    task automatic chk_sp(input string tag, input logic [1:0] exp);
        n_assert++;
        assert (dut.u_stack.r_sp === exp) else begin
            n_fail++;
            $error("FAIL %s: sp observed %0d expected %0d", tag, dut.u_stack.r_sp, exp);
        end
    endtask

    task automatic jump(input logic [11:0] a);
        cyc(0, 1, 1, 0, 0, 0, a);
    endtask

    task automatic push();
        cyc(0, 0, 0, 1, 0, 0, 12'h000);
    endtask

    task automatic pop();
        cyc(0, 1, 0, 0, 0, 0, 12'h000);
    endtask

    initial begin
        reset        = 1'b1;
        bus.dmaload  = 1'b0;
        bus.load_pc  = 1'b0;
        bus.dmapush  = 1'b0;
        bus.latch0   = 1'b0;
        bus.latch2   = 1'b0;
        bus.count_in = 12'h000;
        @(posedge clk);
        #1;
        cyc(1, 0, 0, 0, 0, 0, 12'h000);
        chk_pc("por", 12'h000);
        chk_sp("por_sp", 2'd0);

        // Reset from a non-trivial state, with strobes active.
        jump(12'h321);
        chk_pc("pre_jump", 12'h321);
        push();
        chk_sp("pre_push_sp", 2'd1);
        cyc(1, 1, 1, 1, 1, 1, 12'h777);
        chk_pc("rst_prio", 12'h000);
        chk_sp("rst_prio_sp", 2'd0);

        // Jump then increment.
        jump(12'hABC);
        chk_pc("jump", 12'hABC);
        cyc(0, 0, 0, 0, 1, 0, 12'h000); chk_pc("inc1", 12'hABD);
        cyc(0, 0, 0, 0, 1, 0, 12'h000); chk_pc("inc2", 12'hABE);
        cyc(0, 0, 0, 0, 1, 0, 12'h000); chk_pc("inc3", 12'hABF);
        cyc(0, 0, 0, 0, 0, 0, 12'h000); chk_pc("idle", 12'hABF);

        // Nested call / return.
        push();
        chk_pc("call1_hold", 12'hABF);
        chk_sp("call1_sp", 2'd1);
        jump(12'hDEF);
        push();
        chk_sp("call2_sp", 2'd2);
        jump(12'h123);
        cyc(0, 0, 0, 0, 1, 0, 12'h000);
        cyc(0, 0, 0, 0, 1, 0, 12'h000);
        cyc(0, 0, 0, 0, 1, 0, 12'h000);
        chk_pc("sub_inc", 12'h126);
        pop();
        chk_pc("ret1", 12'hDEF);
        chk_sp("ret1_sp", 2'd1);
        cyc(0, 0, 0, 0, 0, 0, 12'h000);
        chk_pc("ret_idle", 12'hDEF);
        pop();
        chk_pc("ret2", 12'hABF);
        chk_sp("ret2_sp", 2'd0);

        // Address wrap and dual-latch increment.
        jump(12'hFFF);
        cyc(0, 0, 0, 0, 0, 1, 12'h000);
        chk_pc("wrap", 12'h000);
        cyc(0, 0, 0, 0, 1, 1, 12'h000);
        chk_pc("dual_latch", 12'h001);

        // Priority: load beats push and increment; push beats increment.
        cyc(0, 1, 1, 1, 1, 0, 12'h555);
        chk_pc("prio_load", 12'h555);
        chk_sp("prio_load_sp", 2'd0);
        cyc(0, 0, 0, 1, 1, 0, 12'h000);
        chk_pc("prio_push", 12'h555);
        chk_sp("prio_push_sp", 2'd1);
        pop();
        chk_pc("prio_pop", 12'h555);
        chk_sp("prio_pop_sp", 2'd0);

        // Overflow: fifth push overwrites the oldest entry.
        jump(12'h100); push();
        jump(12'h200); push();
        jump(12'h300); push();
        jump(12'h400); push();
        jump(12'h500); push();
        chk_sp("ovf_sp", 2'd1);
        pop(); chk_pc("ovf_pop_e", 12'h500);
        pop(); chk_pc("ovf_pop_d", 12'h400);
        pop(); chk_pc("ovf_pop_c", 12'h300);
        pop(); chk_pc("ovf_pop_b", 12'h200);
        chk_sp("ovf_end_sp", 2'd1);

        // Underflow from reset returns entry 3.
        cyc(1, 0, 0, 0, 0, 0, 12'h000);
        jump(12'h0F0);
        pop();
        chk_pc("udf_pop", 12'h000);
        chk_sp("udf_sp", 2'd3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
